// File: rtl/call_panel_pkg.sv
// Shared types and defaults for the elevator call panel.
package call_panel_pkg;

    typedef enum logic [1:0] {
        DIR_IDLE,
        DIR_DOWN,
        DIR_UP
    } dir_t;

    localparam int unsigned NUM_FLOORS_DEF = 10;
    localparam int unsigned FLOOR_W_DEF    = 4;
    localparam int unsigned DEBOUNCE_W     = 8;

endpackage

// File: rtl/button_debounce.sv
// One push-button: 2-flop synchroniser, saturating stable-high counter and a
// single-cycle press pulse on the rising edge of the debounced level.
module button_debounce
    import call_panel_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic press
);

    localparam logic [DEBOUNCE_W-1:0] TargetCnt = DEBOUNCE_W'(DEBOUNCE_CYCLES);

    logic [1:0]            sync_q, sync_d;
    logic [DEBOUNCE_W-1:0] cnt_q, cnt_d;
    logic                  level_q, level_d;

    always_comb begin
        sync_d = {sync_q[0], raw};
        cnt_d  = '0;
        if (sync_q[1]) begin
            cnt_d = (cnt_q == TargetCnt) ? cnt_q : cnt_q + DEBOUNCE_W'(1);
        end
        level_d = (cnt_q == TargetCnt);
        press   = level_d & ~level_q;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

endmodule

// File: rtl/call_panel.sv
// Elevator call panel: debounces car and hall buttons, latches calls and clears
// them on service. Optional macro CALL_CANCEL_EN makes car buttons toggle.
module call_panel
    import call_panel_pkg::*;
#(
    parameter int unsigned NUM_FLOORS      = NUM_FLOORS_DEF,
    parameter int unsigned FLOOR_W         = FLOOR_W_DEF,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] raw_inside,
    input  logic [NUM_FLOORS-2:0] raw_up,
    input  logic [NUM_FLOORS-1:1] raw_down,
    input  logic [FLOOR_W-1:0]    floor,
    input  logic                  up_signal,
    input  logic                  down_signal,
    input  logic                  open_door,
    output logic [NUM_FLOORS-1:0] buttons_inside,
    output logic [NUM_FLOORS-2:0] buttons_outside_up,
    output logic [NUM_FLOORS-1:1] buttons_outside_down
);

    logic [NUM_FLOORS-1:0] press_in, hit;
    logic [NUM_FLOORS-2:0] press_up, clr_up;
    logic [NUM_FLOORS-1:1] press_dn, clr_dn;

    logic [NUM_FLOORS-1:0] in_q, in_d;
    logic [NUM_FLOORS-2:0] up_q, up_d;
    logic [NUM_FLOORS-1:1] dn_q, dn_d;
    dir_t                  last_dir_q, last_dir_d;

    logic [31:0] floor_idx;
    assign floor_idx = 32'(floor);

    for (genvar i = 0; i < NUM_FLOORS; i++) begin : g_floor
        // Out-of-range floors never match any index, so they clear nothing.
        assign hit[i] = open_door && (floor_idx == 32'(i));

        button_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_in (
            .clock(clock),
            .reset(reset),
            .raw  (raw_inside[i]),
            .press(press_in[i])
        );

        if (i < NUM_FLOORS - 1) begin : g_up
            localparam bit IsBottom = (i == 0);

            button_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_up (
                .clock(clock),
                .reset(reset),
                .raw  (raw_up[i]),
                .press(press_up[i])
            );

            assign clr_up[i] = hit[i] && ((last_dir_q != DIR_DOWN) || IsBottom);
        end

        if (i > 0) begin : g_dn
            localparam bit IsTop = (i == NUM_FLOORS - 1);

            button_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_dn (
                .clock(clock),
                .reset(reset),
                .raw  (raw_down[i]),
                .press(press_dn[i])
            );

            assign clr_dn[i] = hit[i] && ((last_dir_q != DIR_UP) || IsTop);
        end
    end

    always_comb begin
        last_dir_d = last_dir_q;
        if (up_signal && !down_signal) begin
            last_dir_d = DIR_UP;
        end else if (down_signal && !up_signal) begin
            last_dir_d = DIR_DOWN;
        end

        // Masking with the clear vectors gives service priority over new presses.
`ifdef CALL_CANCEL_EN
        in_d = (in_q ^ press_in) & ~hit;
`else
        in_d = (in_q | press_in) & ~hit;
`endif
        up_d = (up_q | press_up) & ~clr_up;
        dn_d = (dn_q | press_dn) & ~clr_dn;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            in_q       <= '0;
            up_q       <= '0;
            dn_q       <= '0;
            last_dir_q <= DIR_IDLE;
        end else begin
            in_q       <= in_d;
            up_q       <= up_d;
            dn_q       <= dn_d;
            last_dir_q <= last_dir_d;
        end
    end

    assign buttons_inside       = in_q;
    assign buttons_outside_up   = up_q;
    assign buttons_outside_down = dn_q;

endmodule

// File: doc/call_panel.md
Name: call_panel

Overview:
- Request-producer side of the elevator button interface.
- Takes raw, bouncy push-buttons (car panel plus hall up/down) and synchronises and debounces them.
- Latches each call and drives the request vectors consumed by elev_ctrl, with the same lamp bits for indicators.
- Clears each latched call when the controller services it, i.e. door open at that floor in a compatible direction.

Parameters:
- NUM_FLOORS, 10: floors 0..NUM_FLOORS-1.
- FLOOR_W, 4: width of the floor index; must satisfy 2**FLOOR_W >= NUM_FLOORS.
- DEBOUNCE_CYCLES, 4: consecutive stable-high synchronised samples needed to accept a press; legal range 1..255.

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- raw_inside  in  NUM_FLOORS  raw car-panel buttons.
- raw_up  in  NUM_FLOORS-1  raw hall up buttons, floors 0..NUM_FLOORS-2.
- raw_down  in  NUM_FLOORS-1  raw hall down buttons, floors 1..NUM_FLOORS-1, indexed [NUM_FLOORS-1:1].
- floor  in  FLOOR_W  current car floor from elev_ctrl.
- up_signal  in  1  car moving up.
- down_signal  in  1  car moving down.
- open_door  in  1  door open at floor.
- buttons_inside  out  NUM_FLOORS  latched car calls.
- buttons_outside_up  out  NUM_FLOORS-1  latched hall up calls.
- buttons_outside_down  out  NUM_FLOORS-1  latched hall down calls, [NUM_FLOORS-1:1].

Behaviour:
- Clock and reset: one clock domain. Reset is sampled on the clock edge with reset==0.
- Reset values:
  - All outputs 0.
  - Synchronisers, debounce counters and debounced levels 0.
  - last_dir = DIR_IDLE.
- Synchronisation: every raw bit passes through a 2-flop synchroniser.
- Debounce:
  - A per-button counter increments while the synchronised level is 1, saturating at DEBOUNCE_CYCLES.
  - The counter is cleared to 0 on any synchronised 0.
  - The debounced level rises when the counter reaches DEBOUNCE_CYCLES.
  - Only the 0->1 transition of the debounced level is a press. Holding a button generates exactly one press.
- Latency: raw held high from sampling edge k makes the output bit visible after edge k+DEBOUNCE_CYCLES+2 (6 edges at the default).
- Direction tracker:
  - last_dir <= DIR_UP when up_signal=1.
  - last_dir <= DIR_DOWN when down_signal=1.
  - last_dir is held otherwise.
  - up_signal and down_signal both 1 is illegal; the tracker holds and the bench flags it.
- Service clear, each cycle with open_door=1 and floor f < NUM_FLOORS:
  - Clear buttons_inside[f].
  - Clear buttons_outside_up[f] if last_dir is DIR_UP or DIR_IDLE, or if f==0.
  - Clear buttons_outside_down[f] if last_dir is DIR_DOWN or DIR_IDLE, or if f==NUM_FLOORS-1.
  - Non-existent bits (up at top floor, down at floor 0) are never touched.
- Out-of-range floor (>= NUM_FLOORS): no clear occurs.
- Simultaneous events:
  - Clear has priority over set for the same bit in the same cycle.
  - A press at floor f is discarded while open_door=1 and floor==f and the service rule would clear that bit (the call is already being served).
- Presses on already-latched bits: no effect, subject to the optional feature below.
- Reset mid-operation: all latched calls are lost. Buttons still held after reset release re-register only after a fresh full debounce.

Optional Feature:
- Macro: CALL_CANCEL_EN.
- Defined: a press on an inside button whose call is already latched clears that call on the same edge the press is recognised (toggle semantics, passenger cancel). Hall calls are unaffected. A service clear and a cancel in the same cycle leave the bit 0.
- Undefined: a repeat press on a latched call is ignored.

Decomposition:
- Package call_panel_pkg holds:
  - typedef enum logic [1:0] dir_t {DIR_IDLE, DIR_DOWN, DIR_UP};
  - localparams NUM_FLOORS_DEF=10, FLOOR_W_DEF=4, DEBOUNCE_W=8.
- Sub-module button_debounce (parameter DEBOUNCE_CYCLES) is natural:
  - Contains the synchroniser, saturating counter and press-pulse output for one bit.
  - call_panel instantiates it 3*NUM_FLOORS-2 times via generate.

Test Plan:
- Reset and debounce latency: hold reset=0 for 3 cycles -> all outputs 0. Release reset, then hold raw_inside[4]=1 from edge k -> buttons_inside==10'b0000010000 after edge k+6 and not before.
- Bounce rejection: raw_up[3] toggles 1,1,1,0,1,1,1,0 for 8 cycles -> buttons_outside_up stays 0. Then holding it high for 6 cycles -> buttons_outside_up[3]=1.
- Directional clear:
  - Latch up[5] and down[5]; drive up_signal=1 for 2 cycles, then floor=5, open_door=1 -> up[5] clears, down[5] remains 1.
  - Repeat with down_signal=1 -> down[5] clears, up[5] remains 1.
- Idle and boundaries: last_dir=DIR_IDLE, floor=0, open_door=1 with inside[0] and up[0] latched -> both clear. floor=9 with down[9] latched -> clears. floor=12 with open_door=1 -> nothing changes.
- Press during service: floor=2, open_door=1, last_dir=DIR_IDLE; debounced press on raw_inside[2] -> buttons_inside[2] never asserts. Same press on raw_inside[7] -> bit 7 latches.
- CALL_CANCEL_EN:
  - Defined: latch inside[6], release, press again -> bit 6 returns to 0.
  - Undefined: the same sequence leaves bit 6 at 1.
  - Both builds: mid-operation reset=0 for 1 cycle clears all latched calls.
